// File: rtl/tlc_monitor_pkg.sv
// ============================================================================
// Module      : tlc_monitor_pkg
// Description : Shared light encodings, fault codes and encoding helper for
//               the traffic-light safety monitor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tlc_monitor_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // Numeric order doubles as priority order: lower code wins.
    typedef enum logic [2:0] {
        FLT_NONE         = 3'd0,
        FLT_ENCODING     = 3'd1,
        FLT_CONFLICT     = 3'd2,
        FLT_SEQUENCE     = 3'd3,
        FLT_YELLOW_SHORT = 3'd4,
        FLT_CLEARANCE    = 3'd5,
        FLT_STUCK        = 3'd6
    } fault_code_t;

    function automatic logic is_onehot(input logic [2:0] code);
        return (code == GREEN) || (code == YELLOW) || (code == RED);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_head_checker.sv
// ============================================================================
// Module      : tlc_head_checker
// Description : Per-head encoding, transition and yellow-duration checks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlc_head_checker
    import tlc_monitor_pkg::*;
#(
    parameter int YELLOW_MIN = 4,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic       enc_err,
    output logic       seq_err,
    output logic       yellow_short,
    output logic       entering_green
);

    localparam logic [CW-1:0] c_yellow_min = CW'(YELLOW_MIN);
    localparam logic [CW-1:0] c_cnt_max    = '1;
    localparam logic [CW-1:0] c_one        = CW'(1);

    logic [2:0]    r_prev;
    logic [CW-1:0] r_yellow_cnt;
    logic          w_valid;
    logic          w_legal;

    always_comb begin
        w_valid        = is_onehot(light);
        w_legal        = (light == r_prev)
                       || ((r_prev == GREEN)  && (light == YELLOW))
                       || ((r_prev == YELLOW) && (light == RED))
                       || ((r_prev == RED)    && (light == GREEN));
        enc_err        = !w_valid;
        seq_err        = w_valid && !w_legal;
        yellow_short   = (r_prev == YELLOW) && (light == RED) && (r_yellow_cnt < c_yellow_min);
        entering_green = (r_prev == RED) && (light == GREEN);
    end

    // r_yellow_cnt holds the number of consecutive yellow samples seen,
    // including the first one, so a yellow held N cycles reads N at the red edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= RED;
            r_yellow_cnt <= '0;
        end else begin
            r_prev <= light;
            if (light == YELLOW) begin
                if (r_prev != YELLOW) begin
                    r_yellow_cnt <= c_one;
                end else if (r_yellow_cnt != c_cnt_max) begin
                    r_yellow_cnt <= r_yellow_cnt + c_one;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlc_light_monitor.sv
// ============================================================================
// Module      : tlc_light_monitor
// Description : Traffic-light safety monitor with sticky first-fault latch.
//               Optional fault event counter enabled by TLC_FAULT_COUNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlc_light_monitor
    import tlc_monitor_pkg::*;
#(
    parameter int YELLOW_MIN = 4,
    parameter int ALLRED_MIN = 0,
    parameter int STUCK_MAX  = 64,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_NS,
    input  logic [2:0] light_EW,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_req,
    output logic [7:0] fault_count
);

    localparam logic [CW-1:0] c_cnt_max    = '1;
    localparam logic [CW-1:0] c_one        = CW'(1);
    localparam logic [CW-1:0] c_stuck_last = CW'(STUCK_MAX - 1);

    logic          ns_enc, ns_seq, ns_ys, ns_green;
    logic          ew_enc, ew_seq, ew_ys, ew_green;
    logic [5:0]    r_prev_pair;
    logic [CW-1:0] r_allred_cnt;
    logic [CW-1:0] r_stuck_cnt;
    logic          r_fault;
    fault_code_t   r_code;
    logic          w_conflict, w_both_red, w_same, w_stuck, w_clearance, w_violation;
    fault_code_t   w_code;

    tlc_head_checker #(.YELLOW_MIN(YELLOW_MIN), .CW(CW)) u_head_ns (
        .clk(clk), .rst(rst), .light(light_NS),
        .enc_err(ns_enc), .seq_err(ns_seq), .yellow_short(ns_ys), .entering_green(ns_green)
    );

    tlc_head_checker #(.YELLOW_MIN(YELLOW_MIN), .CW(CW)) u_head_ew (
        .clk(clk), .rst(rst), .light(light_EW),
        .enc_err(ew_enc), .seq_err(ew_seq), .yellow_short(ew_ys), .entering_green(ew_green)
    );

    generate
        if (ALLRED_MIN > 0) begin : g_clearance
            localparam logic [CW-1:0] c_allred_min = CW'(ALLRED_MIN);
            assign w_clearance = (ns_green || ew_green) && (r_allred_cnt < c_allred_min);
        end else begin : g_no_clearance
            assign w_clearance = 1'b0;
        end
    endgenerate

    // Stuck fires only on the sample that brings the counter to STUCK_MAX;
    // afterwards the counter moves past it, so a held pair reports once.
    always_comb begin
        w_conflict = (light_NS != RED) && (light_EW != RED);
        w_both_red = (light_NS == RED) && (light_EW == RED);
        w_same     = ({light_NS, light_EW} == r_prev_pair);
        w_stuck    = w_same && (r_stuck_cnt == c_stuck_last);

        w_code = FLT_NONE;
        if (ns_enc || ew_enc)      w_code = FLT_ENCODING;
        else if (w_conflict)       w_code = FLT_CONFLICT;
        else if (ns_seq || ew_seq) w_code = FLT_SEQUENCE;
        else if (ns_ys || ew_ys)   w_code = FLT_YELLOW_SHORT;
        else if (w_clearance)      w_code = FLT_CLEARANCE;
        else if (w_stuck)          w_code = FLT_STUCK;
        w_violation = (w_code != FLT_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_pair  <= {RED, RED};
            r_allred_cnt <= c_cnt_max;
            r_stuck_cnt  <= '0;
        end else begin
            r_prev_pair <= {light_NS, light_EW};
            if (!w_both_red)                    r_allred_cnt <= '0;
            else if (r_allred_cnt != c_cnt_max) r_allred_cnt <= r_allred_cnt + c_one;
            if (!w_same)                        r_stuck_cnt  <= '0;
            else if (r_stuck_cnt != c_cnt_max)  r_stuck_cnt  <= r_stuck_cnt + c_one;
        end
    end

    // A violation coinciding with a clear re-latches with the new code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
            r_code  <= FLT_NONE;
        end else if (w_violation && (!r_fault || fault_clr)) begin
            r_fault <= 1'b1;
            r_code  <= w_code;
        end else if (!w_violation && fault_clr) begin
            r_fault <= 1'b0;
            r_code  <= FLT_NONE;
        end
    end

`ifdef TLC_FAULT_COUNT_EN
    logic [7:0] r_fault_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_count <= 8'd0;
        end else if (w_violation && (r_fault_count != 8'hFF)) begin
            r_fault_count <= r_fault_count + 8'd1;
        end
    end

    assign fault_count = r_fault_count;
`else
    assign fault_count = 8'd0;
`endif

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign flash_req  = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_tlc_light_monitor.sv
// ============================================================================
// Module      : tb_tlc_light_monitor
// Description : Randomized and directed bench for tlc_light_monitor, two
//               instances (ALLRED_MIN 0 and 3) checked against a run-length model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlc_light_monitor;

    localparam int         YELLOW_MIN = 4;
    localparam int         STUCK_MAX  = 64;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk;
    logic       rst;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic       fault_clr;
    logic       dut_fault [2];
    logic [2:0] dut_code  [2];
    logic       dut_flash [2];
    logic [7:0] dut_cnt   [2];

    int total = 0;
    int bad   = 0;

    // Reference state: plain run lengths, no saturation needed in range.
    int         amin [2] = '{0, 3};
    logic [2:0] m_pns [2];
    logic [2:0] m_pew [2];
    int         m_yns [2], m_yew [2], m_allred [2], m_same [2];
    int         m_code [2], m_cnt [2];
    bit         m_fault [2];

    tlc_light_monitor u_dut0 (
        .clk(clk), .rst(rst), .light_NS(light_ns), .light_EW(light_ew), .fault_clr(fault_clr),
        .fault(dut_fault[0]), .fault_code(dut_code[0]), .flash_req(dut_flash[0]), .fault_count(dut_cnt[0])
    );

    tlc_light_monitor #(.ALLRED_MIN(3)) u_dut1 (
        .clk(clk), .rst(rst), .light_NS(light_ns), .light_EW(light_ew), .fault_clr(fault_clr),
        .fault(dut_fault[1]), .fault_code(dut_code[1]), .flash_req(dut_flash[1]), .fault_count(dut_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish in time (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pns[k] = R;  m_pew[k] = R;
            m_yns[k] = 0;  m_yew[k] = 0;
            m_allred[k] = 1 << 20;
            m_same[k] = 0; m_fault[k] = 1'b0; m_code[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic head_eval(input logic [2:0] p, input logic [2:0] c, input int yrun,
                             input int allred, input int am,
                             output bit enc, output bit seq, output bit ys, output bit clr_err);
        enc = !(c == G || c == Y || c == R);
        seq = 1'b0; ys = 1'b0; clr_err = 1'b0;
        if (!enc) begin
            seq     = !(p == c || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G));
            ys      = (p == Y) && (c == R) && (yrun < YELLOW_MIN);
            clr_err = (am > 0) && (p == R) && (c == G) && (allred < am);
        end
    endtask

    task automatic model_step(input int k);
        bit e0, s0, y0, c0, e1, s1, y1, c1, conf, same, stk;
        int code;
        head_eval(m_pns[k], light_ns, m_yns[k], m_allred[k], amin[k], e0, s0, y0, c0);
        head_eval(m_pew[k], light_ew, m_yew[k], m_allred[k], amin[k], e1, s1, y1, c1);
        conf      = (light_ns != R) && (light_ew != R);
        same      = (light_ns == m_pns[k]) && (light_ew == m_pew[k]);
        m_same[k] = same ? m_same[k] + 1 : 0;
        stk       = same && (m_same[k] == STUCK_MAX);
        if (e0 || e1)      code = 1;
        else if (conf)     code = 2;
        else if (s0 || s1) code = 3;
        else if (y0 || y1) code = 4;
        else if (c0 || c1) code = 5;
        else if (stk)      code = 6;
        else               code = 0;
        if (code != 0 && (!m_fault[k] || fault_clr)) begin
            m_fault[k] = 1'b1; m_code[k] = code;
        end else if (code == 0 && fault_clr) begin
            m_fault[k] = 1'b0; m_code[k] = 0;
        end
`ifdef TLC_FAULT_COUNT_EN
        if (code != 0 && m_cnt[k] < 255) m_cnt[k]++;
`endif
        m_yns[k]    = (light_ns == Y) ? m_yns[k] + 1 : 0;
        m_yew[k]    = (light_ew == Y) ? m_yew[k] + 1 : 0;
        m_allred[k] = (light_ns == R && light_ew == R) ? m_allred[k] + 1 : 0;
        m_pns[k]    = light_ns;
        m_pew[k]    = light_ew;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_fault%0d", tag, k), int'(dut_fault[k]), int'(m_fault[k]));
            check_eq($sformatf("%s_code%0d",  tag, k), int'(dut_code[k]),  m_code[k]);
            check_eq($sformatf("%s_flash%0d", tag, k), int'(dut_flash[k]), int'(m_fault[k]));
            check_eq($sformatf("%s_count%0d", tag, k), int'(dut_cnt[k]),   m_cnt[k]);
        end
    endtask

    task automatic cycle(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        @(negedge clk);
        light_ns = ns; light_ew = ew; fault_clr = clr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all("cyc");
    endtask

    task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [2:0] a, b;
            logic       c;
            a = ns; b = ew; c = 1'b0;
            if (rnd) begin
                if ($urandom_range(0, 31) == 0) a = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 31) == 0) b = 3'($urandom_range(0, 7));
                c = ($urandom_range(0, 7) == 0);
            end
            cycle(a, b, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; light_ns = R; light_ew = R; fault_clr = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; light_ns = R; light_ew = R; fault_clr = 1'b0;
        model_reset();
        do_reset();

        // Legal full cycle three times: instance 0 must stay clean.
        for (int n = 0; n < 3; n++) begin
            hold(G, R, 16, 0); hold(Y, R, 4, 0);
            hold(R, G, 16, 0); hold(R, Y, 4, 0);
        end
        check_eq("legal_fault", int'(dut_fault[0]), 0);

        // Yellow too short.
        do_reset();
        hold(G, R, 3, 0); hold(Y, R, 2, 0); hold(R, R, 1, 0);
        check_eq("ys_fault", int'(dut_fault[0]), 1);
        check_eq("ys_code",  int'(dut_code[0]),  4);
        check_eq("ys_flash", int'(dut_flash[0]), 1);

        // Conflict, then encoding outranking conflict.
        do_reset();
        hold(G, R, 2, 0); hold(G, Y, 1, 0);
        check_eq("conf_code", int'(dut_code[0]), 2);
        do_reset();
        hold(G, R, 2, 0); hold(3'b011, Y, 1, 0);
        check_eq("prio_code", int'(dut_code[0]), 1);

        // Sequence error, clear interactions.
        do_reset();
        hold(G, R, 2, 0); hold(R, R, 1, 0);
        check_eq("seq_code", int'(dut_code[0]), 3);
        cycle(3'b000, R, 1'b1);
        check_eq("relatch_code", int'(dut_code[0]), 1);
        cycle(R, R, 1'b0);
        cycle(R, R, 1'b1);
        check_eq("clr_fault", int'(dut_fault[0]), 0);
        check_eq("clr_code",  int'(dut_code[0]),  0);
        cycle(3'b000, R, 1'b1);
        check_eq("clrviol_fault", int'(dut_fault[0]), 1);
        check_eq("clrviol_code",  int'(dut_code[0]),  1);

        // All-red clearance on the ALLRED_MIN=3 instance.
        do_reset();
        hold(G, R, 2, 0); hold(Y, R, 4, 0); hold(R, R, 1, 0); hold(R, G, 1, 0);
        check_eq("clrnc_code1",  int'(dut_code[1]),  5);
        check_eq("clrnc_fault0", int'(dut_fault[0]), 0);
        do_reset();
        hold(G, R, 2, 0); hold(Y, R, 4, 0); hold(R, R, 3, 0); hold(R, G, 1, 0);
        check_eq("clrok_fault1", int'(dut_fault[1]), 0);

        // Stuck pair: fires once, so a later clear sticks.
        do_reset();
        hold(G, R, 64, 0);
        check_eq("stuck_pre", int'(dut_fault[0]), 0);
        hold(G, R, 1, 0);
        check_eq("stuck_code", int'(dut_code[0]), 6);
        hold(G, R, 3, 0);
        cycle(G, R, 1'b1);
        check_eq("stuck_once", int'(dut_fault[0]), 0);

        // Fault counter saturation.
        do_reset();
        hold(3'b000, R, 300, 0);
`ifdef TLC_FAULT_COUNT_EN
        check_eq("cnt_sat", int'(dut_cnt[0]), 255);
`else
        check_eq("cnt_off", int'(dut_cnt[0]), 0);
`endif

        // Asynchronous reset mid-phase, then monitoring resumes.
        do_reset();
        hold(G, R, 5, 0); hold(R, R, 1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst");
        check_eq("arst_fault", int'(dut_fault[0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold(G, R, 2, 0);
        check_eq("resume_fault", int'(dut_fault[0]), 0);

        // Randomized phase walk with corruption and random clears.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            hold(G, R, ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(1, 20)), 1);
            hold(Y, R, $urandom_range(2, 6), 1);
            hold(R, R, $urandom_range(0, 4), 1);
            hold(R, G, $urandom_range(1, 20), 1);
            hold(R, Y, $urandom_range(2, 6), 1);
            hold(R, R, $urandom_range(0, 4), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
